ram_rw_arbiter: RTL and testbench

RAM_RW_ARBITER -- requirements
Module: ram_rw_arbiter

---
 rtl/ram_rw_arbiter.sv | 104 ++++++++++
 tb/tb_ram_rw_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rw_arbiter.sv
// Arbitrates one write and one read requester onto a single-port synchronous RAM.
// Bursts are bounded by MAX_BURST while the other side waits; reads return two cycles after accept.
module ram_rw_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  w_valid,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_ready,
    input  logic                  r_valid,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_ready,
    output logic                  r_rvalid,
    output logic [DATA_WIDTH-1:0] r_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic {
        OWN_W = 1'b0,
        OWN_R = 1'b1
    } owner_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    owner_t     owner;
    owner_t     acc_owner;
    logic [3:0] burst_cnt;
    logic       grant_w;
    logic       grant_r;
    logic       rd_pend;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_w   = 1'b0;
        grant_r   = 1'b0;
        if (rstn) begin
            if (w_valid && r_valid) begin
                if (burst_cnt == BURST_LIMIT) begin
                    grant_w = (owner == OWN_R);
                end else begin
                    grant_w = (owner == OWN_W);
                end
                grant_r = !grant_w;
            end else begin
                grant_w = w_valid;
                grant_r = r_valid;
            end
        end
        acc_owner = grant_r ? OWN_R : OWN_W;
    end

    assign w_ready = grant_w;
    assign r_ready = grant_r;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner     <= OWN_W;
            burst_cnt <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rd_pend   <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            if (grant_w || grant_r) begin
                if (acc_owner == owner) begin
                    burst_cnt <= (burst_cnt >= BURST_LIMIT) ? BURST_LIMIT : burst_cnt + 4'd1;
                end else begin
                    owner     <= acc_owner;
                    burst_cnt <= 4'd1;
                end
            end else begin
                burst_cnt <= '0;
            end

            ram_en <= grant_w || grant_r;
            ram_we <= grant_w;
            if (grant_w) begin
                ram_addr  <= w_addr;
                ram_wdata <= w_data;
            end else if (grant_r) begin
                ram_addr  <= r_addr;
            end

            rd_pend  <= grant_r;
            r_rvalid <= rd_pend;
        end
    end

    // The RAM presents read data in the cycle after the strobe, so it is passed straight through
    // while r_rvalid is high; zero otherwise, which also covers the reset value.
    assign r_rdata = r_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_rw_arbiter.sv
// Self-checking bench for ram_rw_arbiter: behavioural RAM, grant checks per cycle and a
// scoreboard of expected RAM strobes and read responses.
module tb_ram_rw_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       w_valid, r_valid;
    logic [7:0] w_addr, w_data, r_addr;
    logic       w_ready, r_ready, r_rvalid;
    logic [7:0] r_rdata;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } strobe_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_t;

    strobe_t    st_q[$];
    rd_t        rd_q[$];
    logic [7:0] mem[256];
    logic [7:0] shadow[256];
    logic [7:0] last_wd;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    ram_rw_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rstn(rstn),
        .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready),
        .r_valid(r_valid), .r_addr(r_addr), .r_ready(r_ready),
        .r_rvalid(r_rvalid), .r_rdata(r_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: read data appears in the cycle after the strobe.
    always @(posedge clk) begin
        if (ram_en === 1'b1) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Output monitor: every strobe and every read response must match the scoreboard exactly in time.
    always @(negedge clk) begin
        strobe_t s;
        rd_t     r;
        if (ram_en === 1'b1) begin
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected cyc=%0d we=%b addr=%h", cyc, ram_we, ram_addr);
            end else begin
                s = st_q.pop_front();
                if (ram_we !== s.we || ram_addr !== s.addr || ram_wdata !== s.wdata) begin
                    errors++;
                    $display("FAIL strobe cyc=%0d got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                             cyc, ram_we, ram_addr, ram_wdata, s.we, s.addr, s.wdata);
                end
            end
        end else if (st_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL strobe_missing cyc=%0d ram_en=%b expected 1", cyc, ram_en);
            st_q.delete();
        end

        if (r_rvalid === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected cyc=%0d rdata=%h", cyc, r_rdata);
            end else begin
                r = rd_q.pop_front();
                if (r.due != cyc || r_rdata !== r.data) begin
                    errors++;
                    $display("FAIL rdata cyc=%0d got %h expected %h at cyc=%0d", cyc, r_rdata, r.data, r.due);
                end
            end
        end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL rvalid_missing cyc=%0d expected rdata %h due cyc=%0d", cyc, rd_q[0].data, rd_q[0].due);
            void'(rd_q.pop_front());
        end
    end

    // One clock of stimulus; exp_grant: 0 = none, 1 = write, 2 = read.
    task automatic step(input logic rst_v, input logic wv, input logic [7:0] wa, input logic [7:0] wd,
                        input logic rv, input logic [7:0] ra, input int exp_grant);
        logic gw, gr;
        @(negedge clk);
        rstn    = rst_v;
        w_valid = wv;
        w_addr  = wa;
        w_data  = wd;
        r_valid = rv;
        r_addr  = ra;
        if (!rst_v) begin
            rd_q.delete();
            last_wd = 8'h00;
        end
        #1;
        gw = (exp_grant == 1);
        gr = (exp_grant == 2);
        checks++;
        if (w_ready !== gw || r_ready !== gr) begin
            errors++;
            $display("FAIL grant cyc=%0d got w_ready=%b r_ready=%b expected %b %b", cyc, w_ready, r_ready, gw, gr);
        end
        if (gw) begin
            st_q.push_back('{1'b1, wa, wd});
            shadow[wa] = wd;
            last_wd    = wd;
        end
        if (gr) begin
            st_q.push_back('{1'b0, ra, last_wd});
            rd_q.push_back('{shadow[ra], cyc + 2});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hAA, 8'h55, 1'b1, 8'h33, 0);
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_wdata !== 8'h00 ||
            r_rvalid !== 1'b0 || r_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got en=%b we=%b addr=%h wdata=%h rvalid=%b rdata=%h expected all 0",
                     ram_en, ram_we, ram_addr, ram_wdata, r_rvalid, r_rdata);
        end
    endtask

    task automatic test_write_read();
        step(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1);
        idle(2);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 2);
        idle(3);
    endtask

    task automatic test_burst();
        int exp_seq[10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 8'h20 + 8'(i), 8'h80 + 8'(i), 1'b1, 8'h20 + 8'(i), exp_seq[i]);
        idle(3);
    endtask

    task automatic test_single_then_both();
        int exp_seq[5] = '{2, 2, 2, 2, 1};
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'h40 + 8'(i), 8'hC0 + 8'(i), 1'b0, 8'h00, 1);
        // Write burst is already saturated, so the waiting reader wins at once.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 8'h50 + 8'(i), 8'hD0 + 8'(i), 1'b1, 8'h40 + 8'(i), exp_seq[i]);
        idle(3);
    endtask

    task automatic test_idle_clear();
        int exp_seq[5] = '{1, 1, 1, 1, 2};
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h60 + 8'(i), 8'h11 + 8'(i), 1'b0, 8'h00, 1);
        idle(1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 8'h68 + 8'(i), 8'h21 + 8'(i), 1'b1, 8'h60 + 8'(i), exp_seq[i]);
        idle(3);
    endtask

    task automatic test_reset_discard();
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 2);
        step(1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'h10, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 0);
            checks++;
            if (r_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL discard step=%0d got r_rvalid=%b expected 0", i, r_rvalid);
            end
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, 8'h07, 8'h3C, 1'b0, 8'h00, 1);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h07, 2);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1'b1, 1'b1, 8'h90 + 8'(i), 8'h5A ^ 8'(i), 1'b0, 8'h00, 1);
            else            step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h90 + 8'(i - 1), 2);
        end
        idle(4);
    endtask

    initial begin
        rstn    = 1'b0;
        w_valid = 1'b1;
        r_valid = 1'b1;
        w_addr  = 8'h00;
        w_data  = 8'h00;
        r_addr  = 8'h00;
        last_wd = 8'h00;
        ram_rdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end

        test_reset();
        test_write_read();
        test_burst();
        test_single_then_both();
        test_idle_clear();
        test_reset_discard();
        test_back_to_back();

        checks++;
        if (st_q.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL drain got strobes=%0d reads=%0d pending expected 0 0", st_q.size(), rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
